aud_stream_mixer: RTL

AUD_STREAM_MIXER -- requirements
Module: aud_stream_mixer

---
 rtl/aud_stream_mixer.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/aud_stream_mixer.sv
// aud_stream_mixer: collects one signed sample per voice slot from an AXI-Stream
// style input, then on each sample_tick sums every pending slot sequentially
// (one slot per clock) and presents a saturated mix with the contributing mask.
module aud_stream_mixer #(
    parameter int NUM_VOICES = 8,
    parameter int SAMPLE_W   = 24,
    parameter int ACC_W      = SAMPLE_W + $clog2(NUM_VOICES)
) (
    input  logic                  s00_axis_aud_aclk,
    input  logic                  s00_axis_aud_aresetn,
    input  logic [31:0]           s00_axis_aud_tdata,
    input  logic [2:0]            s00_axis_aud_tid,
    input  logic                  s00_axis_aud_tvalid,
    output logic                  s00_axis_aud_tready,
    input  logic                  sample_tick,
    input  logic                  status_clr,
    output logic [SAMPLE_W-1:0]   mix_data,
    output logic                  mix_valid,
    output logic [NUM_VOICES-1:0] mix_mask,
    output logic                  overwrite_err,
    output logic                  tid_err,
    output logic                  overrun_err
);

    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    // Saturation bounds of the output sample, expressed at accumulator width.
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        $signed({{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}});
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        $signed({{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}});

    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_SUM    = 2'd1,
        ST_OUT    = 2'd2
    } state_t;

    // Sign-extend one slot sample to accumulator width.
    function automatic logic [ACC_W-1:0] sext_fn(input logic [SAMPLE_W-1:0] s);
        sext_fn = ACC_W'($signed(s));
    endfunction

    // Clamp the accumulator into the signed output sample range.
    function automatic logic [SAMPLE_W-1:0] sat_fn(input logic [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] sa;
        sa = $signed(a);
        if (sa > SAT_MAX) begin
            sat_fn = {1'b0, {(SAMPLE_W-1){1'b1}}};
        end else if (sa < SAT_MIN) begin
            sat_fn = {1'b1, {(SAMPLE_W-1){1'b0}}};
        end else begin
            sat_fn = a[SAMPLE_W-1:0];
        end
    endfunction

    state_t                                 state_q, state_d;
    logic                                   tready_q, tready_d;
    logic [NUM_VOICES-1:0]                  pending_q, pending_d;
    logic [NUM_VOICES-1:0]                  mask_q, mask_d;
    logic [NUM_VOICES-1:0][SAMPLE_W-1:0]    slot_q, slot_d;
    logic [ACC_W-1:0]                       acc_q, acc_d;
    logic [IDX_W-1:0]                       idx_q, idx_d;
    logic [SAMPLE_W-1:0]                    mix_data_q, mix_data_d;
    logic [NUM_VOICES-1:0]                  mix_mask_q, mix_mask_d;
    logic                                   mix_valid_q, mix_valid_d;
    logic                                   overwrite_err_q, overwrite_err_d;
    logic                                   tid_err_q, tid_err_d;
    logic                                   overrun_err_q, overrun_err_d;

    logic                                   xfer_s;
    logic                                   tid_bad_s;
    logic                                   good_xfer_s;
    logic [NUM_VOICES-1:0]                  wr_sel_s;
    logic                                   ov_set_s;
    logic                                   tid_set_s;
    logic                                   orun_set_s;
    logic                                   unused_tdata_s;

    // Upper tdata bits carry no audio and are intentionally dropped.
    assign unused_tdata_s = ^s00_axis_aud_tdata[31:SAMPLE_W];

    assign xfer_s      = s00_axis_aud_tvalid & tready_q;
    assign tid_bad_s   = ({29'd0, s00_axis_aud_tid} >= 32'(NUM_VOICES));
    assign good_xfer_s = xfer_s & ~tid_bad_s;
    assign ov_set_s    = good_xfer_s & (|(pending_q & wr_sel_s));
    assign tid_set_s   = xfer_s & tid_bad_s;
    assign orun_set_s  = sample_tick & (state_q != ST_ACCEPT);

    // One-hot decode of the incoming tid onto the slot array.
    always_comb begin
        wr_sel_s = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            wr_sel_s[i] = ({29'd0, s00_axis_aud_tid} == 32'(i));
        end
    end

    // Next-state, datapath and sticky-status logic of the collect/sum/output FSM.
    always_comb begin
        state_d         = state_q;
        tready_d        = 1'b0;
        pending_d       = pending_q;
        mask_d          = mask_q;
        slot_d          = slot_q;
        acc_d           = acc_q;
        idx_d           = idx_q;
        mix_data_d      = mix_data_q;
        mix_mask_d      = mix_mask_q;
        mix_valid_d     = 1'b0;
        // A set event on the same edge as status_clr takes priority.
        overwrite_err_d = (overwrite_err_q & ~status_clr) | ov_set_s;
        tid_err_d       = (tid_err_q & ~status_clr) | tid_set_s;
        overrun_err_d   = (overrun_err_q & ~status_clr) | orun_set_s;

        case (state_q)
            ST_ACCEPT: begin
                if (good_xfer_s) begin
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        if (wr_sel_s[i]) begin
                            slot_d[i]    = s00_axis_aud_tdata[SAMPLE_W-1:0];
                            pending_d[i] = 1'b1;
                        end else begin
                            slot_d[i]    = slot_q[i];
                        end
                    end
                end else begin
                    pending_d = pending_q;
                end
                if (sample_tick) begin
                    // Snapshot includes a beat landing on this same edge.
                    mask_d   = pending_d;
                    acc_d    = '0;
                    idx_d    = '0;
                    state_d  = ST_SUM;
                    tready_d = 1'b0;
                end else begin
                    tready_d = 1'b1;
                end
            end
            ST_SUM: begin
                if (mask_q[idx_q]) begin
                    acc_d = acc_q + sext_fn(slot_q[idx_q]);
                end else begin
                    acc_d = acc_q;
                end
                pending_d[idx_q] = 1'b0;
                if (idx_q == IDX_W'(NUM_VOICES - 1)) begin
                    state_d = ST_OUT;
                    idx_d   = idx_q;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                end
            end
            ST_OUT: begin
                mix_data_d  = sat_fn(acc_q);
                mix_mask_d  = mask_q;
                mix_valid_d = 1'b1;
                state_d     = ST_ACCEPT;
                tready_d    = 1'b1;
            end
            default: begin
                state_d  = ST_ACCEPT;
                tready_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge s00_axis_aud_aclk) begin
        if (!s00_axis_aud_aresetn) begin
            state_q         <= ST_ACCEPT;
            tready_q        <= 1'b0;
            pending_q       <= '0;
            mask_q          <= '0;
            slot_q          <= '0;
            acc_q           <= '0;
            idx_q           <= '0;
            mix_data_q      <= '0;
            mix_mask_q      <= '0;
            mix_valid_q     <= 1'b0;
            overwrite_err_q <= 1'b0;
            tid_err_q       <= 1'b0;
            overrun_err_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            tready_q        <= tready_d;
            pending_q       <= pending_d;
            mask_q          <= mask_d;
            slot_q          <= slot_d;
            acc_q           <= acc_d;
            idx_q           <= idx_d;
            mix_data_q      <= mix_data_d;
            mix_mask_q      <= mix_mask_d;
            mix_valid_q     <= mix_valid_d;
            overwrite_err_q <= overwrite_err_d;
            tid_err_q       <= tid_err_d;
            overrun_err_q   <= overrun_err_d;
        end
    end

    assign s00_axis_aud_tready = tready_q;
    assign mix_data            = mix_data_q;
    assign mix_mask            = mix_mask_q;
    assign mix_valid           = mix_valid_q;
    assign overwrite_err       = overwrite_err_q;
    assign tid_err             = tid_err_q;
    assign overrun_err         = overrun_err_q;

endmodule
